spi_rx_frontend: RTL and testbench

- Serial-capture front end that sits directly upstream of the serial-in/parallel-out word register in the audio control path.
- Synchronises the external SPI pins (sck, mosi, cs_n) into the clk domain and detects the sampling edge of sck.
- Emits one-cycle bit strobes (bit_out/bit_valid) that drive the SIPO's in/enable directly.
- Tracks word and frame boundaries, and flags frames that end mid-word so the SIPO can be flushed.

---
 rtl/spi_rx_frontend_pkg.sv | 15 +
 rtl/spi_rx_frontend_sync_chain.sv | 24 ++
 rtl/spi_rx_frontend.sv | 134 +++++++++++++
 tb/tb_spi_rx_frontend.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_rx_frontend_pkg.sv
// Shared constants for the SPI receive front end and the downstream SIPO word register.
package spi_rx_frontend_pkg;

    localparam int unsigned CPOL_RISING        = 0;
    localparam int unsigned CPOL_FALLING       = 1;
    localparam int unsigned SPI_MIN_OVERSAMPLE = 4;
    localparam int unsigned WORD_WIDTH         = 32;

    // True when synced sck moved onto the sampling level for the given polarity.
    function automatic logic is_sample_edge(input logic falling, input logic prev,
                                            input logic cur);
        return falling ? (prev & ~cur) : (~prev & cur);
    endfunction

endpackage

// File: rtl/spi_rx_frontend_sync_chain.sv
// Single-bit multi-flop synchroniser with a configurable idle (reset) value.
module sync_chain #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_q <= {STAGES{RESET_VAL}};
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_rx_frontend.sv
// SPI receive front end: synchronises pins, strobes sampled bits into the SIPO and
// tracks word/frame boundaries.
module spi_rx_frontend
    import spi_rx_frontend_pkg::*;
#(
    parameter int unsigned WIDTH       = WORD_WIDTH,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CPOL        = CPOL_RISING,
    parameter int unsigned WORD_CNT_W  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  sck_i,
    input  logic                  mosi_i,
    input  logic                  cs_n_i,
    output logic                  bit_out_o,
    output logic                  bit_valid_o,
    output logic                  word_done_o,
    output logic                  frame_start_o,
    output logic                  frame_end_o,
    output logic                  frame_error_o,
    output logic                  busy_o,
    output logic [7:0]            bit_cnt_o,
    output logic [WORD_CNT_W-1:0] word_cnt_o
);

    localparam logic        SckIdle = (CPOL == CPOL_FALLING);
    localparam int unsigned SettleW = $clog2(SYNC_STAGES + 1);

    logic sck_s, mosi_s, cs_n_s;

    sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(SckIdle)) u_sync_sck (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (sck_i),
        .q_o   (sck_s)
    );

    sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (mosi_i),
        .q_o   (mosi_s)
    );

    sync_chain #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs_n (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .d_i   (cs_n_i),
        .q_o   (cs_n_s)
    );

    logic                  sck_hist_q, cs_hist_q;
    logic [SettleW-1:0]    settle_q;
    logic                  armed_q, in_frame_q;
    logic                  bit_out_q, bit_valid_q, word_done_q;
    logic                  frame_start_q, frame_end_q, frame_error_q;
    logic [7:0]            bit_cnt_q;
    logic [WORD_CNT_W-1:0] word_cnt_q;

    logic sample_edge, frame_start, frame_end, accept, last_bit, flushed;

    // A frame may only open after a genuine (post-flush) cs_n high has been observed, so a
    // reset taken while cs_n is held low cannot fabricate a frame_start.
    always_comb begin
        flushed     = (settle_q == SettleW'(SYNC_STAGES));
        sample_edge = is_sample_edge(SckIdle, sck_hist_q, sck_s);
        frame_start = ~in_frame_q & armed_q & cs_hist_q & ~cs_n_s;
        frame_end   = in_frame_q & cs_n_s;
        accept      = sample_edge & in_frame_q & ~cs_n_s;
        last_bit    = (bit_cnt_q == 8'(WIDTH - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sck_hist_q    <= SckIdle;
            cs_hist_q     <= 1'b1;
            settle_q      <= '0;
            armed_q       <= 1'b0;
            in_frame_q    <= 1'b0;
            bit_out_q     <= 1'b0;
            bit_valid_q   <= 1'b0;
            word_done_q   <= 1'b0;
            frame_start_q <= 1'b0;
            frame_end_q   <= 1'b0;
            frame_error_q <= 1'b0;
            bit_cnt_q     <= '0;
            word_cnt_q    <= '0;
        end else begin
            sck_hist_q    <= sck_s;
            cs_hist_q     <= cs_n_s;
            if (!flushed) begin
                settle_q <= settle_q + 1'b1;
            end
            armed_q       <= armed_q | (flushed & cs_n_s);
            bit_valid_q   <= accept;
            word_done_q   <= accept & last_bit;
            frame_start_q <= frame_start;
            frame_end_q   <= frame_end;
            frame_error_q <= frame_end & (bit_cnt_q != 8'd0);
            if (accept) begin
                bit_out_q <= mosi_s;
            end
            if (frame_start) begin
                in_frame_q <= 1'b1;
                bit_cnt_q  <= '0;
                word_cnt_q <= '0;
            end else if (frame_end) begin
                in_frame_q <= 1'b0;
                bit_cnt_q  <= '0;
            end else if (accept) begin
                if (last_bit) begin
                    bit_cnt_q <= '0;
                    if (word_cnt_q != {WORD_CNT_W{1'b1}}) begin
                        word_cnt_q <= word_cnt_q + 1'b1;
                    end
                end else begin
                    bit_cnt_q <= bit_cnt_q + 8'd1;
                end
            end
        end
    end

    assign bit_out_o     = bit_out_q;
    assign bit_valid_o   = bit_valid_q;
    assign word_done_o   = word_done_q;
    assign frame_start_o = frame_start_q;
    assign frame_end_o   = frame_end_q;
    assign frame_error_o = frame_error_q;
    assign busy_o        = in_frame_q;
    assign bit_cnt_o     = bit_cnt_q;
    assign word_cnt_o    = word_cnt_q;

endmodule

// File: tb/tb_spi_rx_frontend.sv
// Randomised bench for spi_rx_frontend: three instances (CPOL=0, CPOL=1, 2-bit word counter)
// checked every cycle against a pin-level behavioural model plus literal scenario checks.
module tb_spi_rx_frontend;

    localparam int unsigned W = 32;
    localparam int unsigned S = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sck = 1'b0;
    logic mosi = 1'b0;
    logic cs_n = 1'b1;
    logic sck_inv;

    always #5 clk = ~clk;
    assign sck_inv = ~sck;

    logic       bo[3], bv[3], wd[3], fs[3], fe[3], ferr[3], busy[3];
    logic [7:0] bc[3];
    logic [7:0] wc0, wc1;
    logic [1:0] wc2;

    spi_rx_frontend #(.WIDTH(W), .SYNC_STAGES(S), .CPOL(0), .WORD_CNT_W(8)) dut0 (
        .clk_i(clk), .rst_i(rst), .sck_i(sck), .mosi_i(mosi), .cs_n_i(cs_n),
        .bit_out_o(bo[0]), .bit_valid_o(bv[0]), .word_done_o(wd[0]),
        .frame_start_o(fs[0]), .frame_end_o(fe[0]), .frame_error_o(ferr[0]),
        .busy_o(busy[0]), .bit_cnt_o(bc[0]), .word_cnt_o(wc0)
    );

    spi_rx_frontend #(.WIDTH(W), .SYNC_STAGES(S), .CPOL(1), .WORD_CNT_W(8)) dut1 (
        .clk_i(clk), .rst_i(rst), .sck_i(sck_inv), .mosi_i(mosi), .cs_n_i(cs_n),
        .bit_out_o(bo[1]), .bit_valid_o(bv[1]), .word_done_o(wd[1]),
        .frame_start_o(fs[1]), .frame_end_o(fe[1]), .frame_error_o(ferr[1]),
        .busy_o(busy[1]), .bit_cnt_o(bc[1]), .word_cnt_o(wc1)
    );

    spi_rx_frontend #(.WIDTH(W), .SYNC_STAGES(S), .CPOL(0), .WORD_CNT_W(2)) dut2 (
        .clk_i(clk), .rst_i(rst), .sck_i(sck), .mosi_i(mosi), .cs_n_i(cs_n),
        .bit_out_o(bo[2]), .bit_valid_o(bv[2]), .word_done_o(wd[2]),
        .frame_start_o(fs[2]), .frame_end_o(fe[2]), .frame_error_o(ferr[2]),
        .busy_o(busy[2]), .bit_cnt_o(bc[2]), .word_cnt_o(wc2)
    );

    // ---------------- behavioural model (pin view delayed by S clocks) ----------------
    bit          q_sck[$], q_cs[$], q_mosi[$], q_real[$];
    bit          m_prev_sck, m_prev_cs, m_armed, m_in_frame;
    int unsigned m_bits, m_words;
    logic        e_bo, e_bv, e_wd, e_fs, e_fe, e_ferr;

    always @(posedge clk) begin
        bit v_sck, v_cs, v_mosi, v_real, rise;
        if (rst) begin
            q_sck.delete(); q_cs.delete(); q_mosi.delete(); q_real.delete();
            for (int k = 0; k < S; k++) begin
                q_sck.push_back(1'b0); q_cs.push_back(1'b1);
                q_mosi.push_back(1'b0); q_real.push_back(1'b0);
            end
            m_prev_sck = 1'b0; m_prev_cs = 1'b1; m_armed = 1'b0; m_in_frame = 1'b0;
            m_bits = 0; m_words = 0;
            {e_bo, e_bv, e_wd, e_fs, e_fe, e_ferr} = '0;
        end else begin
            v_sck = q_sck.pop_front(); v_cs = q_cs.pop_front();
            v_mosi = q_mosi.pop_front(); v_real = q_real.pop_front();
            q_sck.push_back(sck); q_cs.push_back(cs_n);
            q_mosi.push_back(mosi); q_real.push_back(1'b1);
            rise   = v_sck && !m_prev_sck;
            e_fs   = !m_in_frame && m_armed && m_prev_cs && !v_cs;
            e_fe   = m_in_frame && v_cs;
            e_bv   = m_in_frame && !v_cs && rise;
            e_ferr = e_fe && (m_bits != 0);
            e_wd   = e_bv && (m_bits == W - 1);
            if (e_bv) e_bo = v_mosi;
            if (e_fs) begin
                m_in_frame = 1'b1; m_bits = 0; m_words = 0;
            end else if (e_fe) begin
                m_in_frame = 1'b0; m_bits = 0;
            end else if (e_bv) begin
                m_bits = (m_bits + 1) % W;
                if (m_bits == 0) m_words++;
            end
            if (v_real && v_cs) m_armed = 1'b1;
            m_prev_sck = v_sck; m_prev_cs = v_cs;
        end
    end

    // ---------------- compare + monitor (sole owner of the counters) ----------------
    int unsigned n_vec = 0, n_err = 0;
    int unsigned mon_bv = 0, mon_wd = 0, mon_fe = 0, mon_ferr = 0, mon_fs = 0;
    logic [31:0] word0 = '0, word1 = '0;
    string       lit_nm;
    logic [31:0] lit_act, lit_exp;
    int unsigned lit_seq = 0, lit_seen = 0;

    task automatic chk(input string nm, input int i, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s dut%0d at %0t: got %0h want %0h", nm, i, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            logic [31:0] wc_act, wc_exp;
            wc_act = (i == 0) ? 32'(wc0) : (i == 1) ? 32'(wc1) : 32'(wc2);
            wc_exp = (i == 2) ? ((m_words > 3) ? 3 : m_words)
                              : ((m_words > 255) ? 255 : m_words);
            chk("bit_valid", i, 32'(bv[i]), 32'(e_bv));
            chk("bit_out", i, 32'(bo[i]), 32'(e_bo));
            chk("word_done", i, 32'(wd[i]), 32'(e_wd));
            chk("frame_start", i, 32'(fs[i]), 32'(e_fs));
            chk("frame_end", i, 32'(fe[i]), 32'(e_fe));
            chk("frame_error", i, 32'(ferr[i]), 32'(e_ferr));
            chk("busy", i, 32'(busy[i]), 32'(m_in_frame));
            chk("bit_cnt", i, 32'(bc[i]), m_bits);
            chk("word_cnt", i, wc_act, wc_exp);
        end
        if (bv[0] === 1'b1) begin
            mon_bv++;
            word0 = {word0[30:0], bo[0]};
        end
        if (bv[1] === 1'b1) word1 = {word1[30:0], bo[1]};
        if (wd[0] === 1'b1) mon_wd++;
        if (fe[0] === 1'b1) mon_fe++;
        if (ferr[0] === 1'b1) mon_ferr++;
        if (fs[0] === 1'b1) mon_fs++;
        if (lit_seq != lit_seen) begin
            lit_seen = lit_seq;
            chk({"lit_", lit_nm}, 0, lit_act, lit_exp);
        end
    end

    // ---------------- stimulus ----------------
    int unsigned b_bv, b_wd, b_fe, b_ferr, b_fs;

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic quiet();
        cyc(1);
        #1;
    endtask

    task automatic snap();
        b_bv = mon_bv; b_wd = mon_wd; b_fe = mon_fe; b_ferr = mon_ferr; b_fs = mon_fs;
    endtask

    task automatic lit(input string nm, input logic [31:0] act, input logic [31:0] exp);
        @(posedge clk); #1;
        lit_nm = nm; lit_act = act; lit_exp = exp; lit_seq++;
        @(negedge clk); #1;
    endtask

    task automatic send_bit(input logic b, input int h);
        mosi = b; cyc(h); sck = 1'b1; cyc(h); sck = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w, input int h);
        for (int k = 31; k >= 0; k--) send_bit(w[k], h);
    endtask

    task automatic start_frame();
        cs_n = 1'b0; cyc(4);
    endtask

    task automatic end_frame();
        cyc(2); cs_n = 1'b1; cyc(S + 6);
    endtask

    initial begin
        cyc(3); rst = 1'b0; cyc(10); quiet();
        lit("rst_bit_cnt", 32'(bc[0]), 0);
        lit("rst_busy", 32'(busy[0]), 0);

        // single word, 8x oversampling
        snap(); start_frame(); send_word(32'hA5A5_F00D, 4); end_frame(); quiet();
        lit("w1_bits", mon_bv - b_bv, 32);
        lit("w1_word", word0, 32'hA5A5_F00D);
        lit("w1_word_cpol1", word1, 32'hA5A5_F00D);
        lit("w1_word_done", mon_wd - b_wd, 1);
        lit("w1_word_cnt", 32'(wc0), 1);
        lit("w1_frame_end", mon_fe - b_fe, 1);
        lit("w1_frame_err", mon_ferr - b_ferr, 0);

        // 3 words, then 5 words to saturate the 2-bit counter
        snap(); start_frame();
        for (int k = 0; k < 3; k++) send_word($urandom, $urandom_range(2, 4));
        end_frame(); quiet();
        lit("w3_word_done", mon_wd - b_wd, 3);
        lit("w3_word_cnt", 32'(wc0), 3);
        lit("w3_frame_err", mon_ferr - b_ferr, 0);
        start_frame();
        for (int k = 0; k < 5; k++) send_word($urandom, 2);
        end_frame(); quiet();
        lit("w5_word_cnt", 32'(wc0), 5);
        lit("w5_word_cnt_sat", 32'(wc2), 3);

        // abort after 13 bits, then a clean word
        snap(); start_frame();
        for (int k = 0; k < 13; k++) send_bit(k[0], 3);
        end_frame(); quiet();
        lit("abort_err", mon_ferr - b_ferr, 1);
        lit("abort_bit_cnt", 32'(bc[0]), 0);
        start_frame(); send_word(32'h1234_5678, 3); end_frame(); quiet();
        lit("abort_next_word", word0, 32'h1234_5678);

        // sck activity while deselected
        snap();
        for (int k = 0; k < 5; k++) send_bit(1'b1, 2);
        quiet();
        lit("idle_bits", mon_bv - b_bv, 0);
        lit("idle_busy", 32'(busy[0]), 0);

        // sample edge coinciding with cs_n rise is dropped
        snap(); start_frame();
        for (int k = 0; k < 13; k++) send_bit(1'b1, 2);
        mosi = 1'b0; cyc(3); sck = 1'b1; cs_n = 1'b1; cyc(3); sck = 1'b0; cyc(S + 6); quiet();
        lit("coinc_bits", mon_bv - b_bv, 13);
        lit("coinc_err", mon_ferr - b_ferr, 1);

        // reset mid-frame with cs_n held low
        snap(); start_frame();
        for (int k = 0; k < 20; k++) send_bit(1'b1, 2);
        rst = 1'b1; cyc(1); rst = 1'b0; quiet();
        lit("mrst_busy", 32'(busy[0]), 0);
        lit("mrst_bit_cnt", 32'(bc[0]), 0);
        lit("mrst_word_cnt", 32'(wc0), 0);
        snap();
        for (int k = 0; k < 10; k++) send_bit(1'b1, 2);
        quiet();
        lit("mrst_no_bits", mon_bv - b_bv, 0);
        lit("mrst_no_start", mon_fs - b_fs, 0);
        cs_n = 1'b1; cyc(S + 6);
        snap(); start_frame(); send_word(32'hC0FF_EE11, 2); end_frame(); quiet();
        lit("mrst_word", word0, 32'hC0FF_EE11);
        lit("mrst_bits", mon_bv - b_bv, 32);

        // randomised frames; the model checks every cycle
        for (int f = 0; f < 40; f++) begin
            int nb, h;
            nb = $urandom_range(0, 80);
            h  = $urandom_range(2, 4);
            start_frame();
            for (int k = 0; k < nb; k++) send_bit(1'($urandom), h);
            if ($urandom_range(0, 3) == 0) begin
                cyc(h); sck = 1'b1; cs_n = 1'b1; cyc(h); sck = 1'b0; cyc(S + 6);
            end else begin
                end_frame();
            end
            for (int k = 0; k < $urandom_range(0, 3); k++) send_bit(1'($urandom), 2);
            cyc($urandom_range(0, 5));
        end
        quiet();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
